// File: rtl/i2c_target_pkg.sv
// Shared state encodings and bus-level constants for the I2C target register file.
package i2c_target_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t ADDR      = 3'd1;
  localparam state_t ADDR_ACK  = 3'd2;
  localparam state_t WR_BYTE   = 3'd3;
  localparam state_t WR_ACK    = 3'd4;
  localparam state_t RD_BYTE   = 3'd5;
  localparam state_t RD_ACK    = 3'd6;
  localparam state_t WAIT_STOP = 3'd7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_line_cond.sv
// Two-flop synchroniser plus delay flop for one bus line; reports level and edges.
module i2c_line_cond (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1, s2, dly;

  // Reset to 1 so an idle (pulled-up) bus produces no spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      dly <= 1'b1;
    end else begin
      s1  <= raw;
      s2  <= s1;
      dly <= s2;
    end
  end

  assign lvl  = s2;
  assign rise = s2 & ~dly;
  assign fall = ~s2 & dly;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-addressed register file, auto-increment pointer and host peek port.
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         DEPTH    = 16,
  parameter int         PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [7:0]       wr_byte,
  input  logic [PTR_W-1:0] peek_addr,
  output logic [7:0]       peek_data
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_cond u_scl (
    .clk   (clk),
    .reset (reset),
    .raw   (scl_i),
    .lvl   (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_cond u_sda (
    .clk   (clk),
    .reset (reset),
    .raw   (sda_i),
    .lvl   (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  state_t           state;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift;
  logic [PTR_W-1:0] ptr;
  logic             first_byte;
  logic [7:0]       mem [DEPTH];

  logic       start_det, stop_det, rd_load;
  logic [7:0] rd_data;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rd_data   = mem[ptr];

  // A read byte is fetched either right after a read-address ACK or after a master ACK.
  always_comb begin
    rd_load = 1'b0;
    if (scl_fall && !start_det && !stop_det) begin
      if (state == ADDR_ACK && shift[0] != RW_WRITE)
        rd_load = 1'b1;
      else if (state == RD_ACK && bit_cnt == 4'd9 && shift[0] == I2C_ACK)
        rd_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      ptr        <= '0;
      first_byte <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      wr_stb     <= 1'b0;
      wr_ptr     <= '0;
      wr_byte    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (rd_load) begin
        shift   <= rd_data;
        sda_oe  <= ~rd_data[7];
        ptr     <= ptr + PTR_W'(1);
        bit_cnt <= '0;
        state   <= RD_BYTE;
      end else begin
        case (state)
          ADDR, WR_BYTE: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_lvl};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == ADDR) begin
                if (shift[7:1] == DEV_ADDR) begin
                  state  <= ADDR_ACK;
                  sda_oe <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                end
              end else begin
                // Commit happens on the falling edge so a STOP/START after bit 8 still discards.
                if (first_byte) begin
                  ptr <= shift[PTR_W-1:0];
                end else begin
                  mem[ptr] <= shift;
                  wr_stb   <= 1'b1;
                  wr_ptr   <= ptr;
                  wr_byte  <= shift;
                  ptr      <= ptr + PTR_W'(1);
                end
                state  <= WR_ACK;
                sda_oe <= 1'b1;
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            if (scl_fall) begin
              sda_oe     <= 1'b0;
              bit_cnt    <= '0;
              first_byte <= (state == ADDR_ACK);
              state      <= WR_BYTE;
            end
          end
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end else begin
                sda_oe <= ~shift[6];
                shift  <= {shift[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              shift[0] <= sda_lvl;
              bit_cnt  <= 4'd9;
            end else if (scl_fall && bit_cnt == 4'd9 && shift[0] == I2C_NACK) begin
              state <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) peek_data <= '0;
    else       peek_data <= mem[peek_addr];
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bus-level bench: bit-banged I2C master with scoreboard queues for writes and read data.
module tb_i2c_target_regfile;

  localparam int Q = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [3:0] peek_addr = '0;
  logic       sda_bus;
  logic       sda_oe, busy, wr_stb;
  logic [3:0] wr_ptr;
  logic [7:0] wr_byte, peek_data;

  assign sda_bus = ~(m_low | sda_oe);

  always #5 clk = ~clk;

  i2c_target_regfile #(.DEV_ADDR(7'h50), .DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_stb    (wr_stb),
    .wr_ptr    (wr_ptr),
    .wr_byte   (wr_byte),
    .peek_addr (peek_addr),
    .peek_data (peek_data)
  );

  typedef struct {
    logic [3:0] ptr;
    logic [7:0] data;
  } wr_t;

  int         n_tests = 0;
  int         n_fail = 0;
  int         oe_hits = 0;
  logic       watch_oe = 1'b0;
  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] model [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (watch_oe && sda_oe) oe_hits++;
    if (wr_stb) begin
      if (exp_wr.size() == 0) begin
        check("wr_stb_unexpected", 32'(wr_stb), 32'd0);
      end else begin
        e = exp_wr.pop_front();
        check("wr_ptr", 32'(wr_ptr), 32'(e.ptr));
        check("wr_byte", 32'(wr_byte), 32'(e.data));
      end
    end
  end

  task automatic push_wr(input logic [3:0] p, input logic [7:0] d);
    wr_t e;
    e.ptr = p;
    e.data = d;
    exp_wr.push_back(e);
    model[p] = d;
  endtask

  task automatic start_c();
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic stop_c();
    m_low = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b0; #(2*Q);
  endtask

  task automatic wbit(input logic b);
    m_low = ~b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic rbit(output logic b);
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    b = sda_bus;  #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, input string tag, input logic exp_lvl);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
    check(tag, 32'(a), 32'(exp_lvl));
  endtask

  task automatic recv_byte(input logic mack, input string tag);
    logic [7:0] d;
    logic       b;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(~mack);
    if (exp_rd.size() == 0) begin
      check({tag, "_no_expect"}, 32'(d), 32'hFFFF_FFFF);
    end else begin
      e = exp_rd.pop_front();
      check(tag, 32'(d), 32'(e));
    end
  endtask

  task automatic peek_chk(input logic [3:0] a, input string tag);
    @(negedge clk) peek_addr = a;
    @(negedge clk);
    @(negedge clk);
    check(tag, 32'(peek_data), 32'(model[a]));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_stb", 32'(wr_stb), 32'd0);
    check("rst_peek", 32'(peek_data), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Addressed write with pointer byte then two data bytes
    start_c();
    check("t1_busy_start", 32'(busy), 32'd1);
    push_wr(4'd3, 8'h11);
    push_wr(4'd4, 8'h22);
    send_byte(8'hA0, "t1_addr_ack", 1'b0);
    send_byte(8'h03, "t1_ptr_ack", 1'b0);
    send_byte(8'h11, "t1_d0_ack", 1'b0);
    send_byte(8'h22, "t1_d1_ack", 1'b0);
    stop_c();
    repeat (4) @(negedge clk);
    check("t1_busy_stop", 32'(busy), 32'd0);
    peek_chk(4'd3, "t1_peek3");
    peek_chk(4'd4, "t1_peek4");

    // Wrong address: NACK and SDA never pulled by the target
    oe_hits = 0;
    watch_oe = 1'b1;
    start_c();
    send_byte(8'hA2, "t2_addr_nack", 1'b1);
    send_byte(8'h00, "t2_data_nack", 1'b1);
    stop_c();
    watch_oe = 1'b0;
    check("t2_oe_quiet", 32'(oe_hits), 32'd0);

    // Preload 14,15,0 through a wrapping write, then sequential read with repeated START
    start_c();
    send_byte(8'hA0, "t3_pre_addr", 1'b0);
    send_byte(8'h0E, "t3_pre_ptr", 1'b0);
    push_wr(4'd14, 8'h5A);
    send_byte(8'h5A, "t3_pre_d0", 1'b0);
    push_wr(4'd15, 8'hA5);
    send_byte(8'hA5, "t3_pre_d1", 1'b0);
    push_wr(4'd0, 8'h3C);
    send_byte(8'h3C, "t3_pre_d2", 1'b0);
    stop_c();
    start_c();
    send_byte(8'hA0, "t3_addr_w", 1'b0);
    send_byte(8'h0E, "t3_ptr", 1'b0);
    start_c();
    send_byte(8'hA1, "t3_addr_r", 1'b0);
    exp_rd.push_back(8'h5A);
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h3C);
    recv_byte(1'b1, "t3_rd0");
    recv_byte(1'b1, "t3_rd1");
    recv_byte(1'b0, "t3_rd2");
    stop_c();
    repeat (4) @(negedge clk);
    check("t3_busy_stop", 32'(busy), 32'd0);

    // Pointer wrap on write
    start_c();
    send_byte(8'hA0, "t4_addr", 1'b0);
    send_byte(8'h0F, "t4_ptr", 1'b0);
    push_wr(4'd15, 8'h77);
    send_byte(8'h77, "t4_d0", 1'b0);
    push_wr(4'd0, 8'h88);
    send_byte(8'h88, "t4_d1", 1'b0);
    stop_c();
    peek_chk(4'd0, "t4_peek0");
    peek_chk(4'd15, "t4_peek15");

    // Partial byte aborted by STOP must not write
    start_c();
    send_byte(8'hA0, "t5_addr", 1'b0);
    send_byte(8'h02, "t5_ptr", 1'b0);
    wbit(1'b1);
    wbit(1'b0);
    wbit(1'b1);
    wbit(1'b1);
    stop_c();
    repeat (4) @(negedge clk);
    check("t5_busy_idle", 32'(busy), 32'd0);
    peek_chk(4'd2, "t5_peek2_kept");
    start_c();
    send_byte(8'hA0, "t5b_addr", 1'b0);
    send_byte(8'h02, "t5b_ptr", 1'b0);
    push_wr(4'd2, 8'h99);
    send_byte(8'h99, "t5b_d0", 1'b0);
    stop_c();
    peek_chk(4'd2, "t5b_peek2");

    // Reset while the target drives a read bit low
    start_c();
    send_byte(8'hA0, "t6_addr_w", 1'b0);
    send_byte(8'h03, "t6_ptr", 1'b0);
    start_c();
    send_byte(8'hA1, "t6_addr_r", 1'b0);
    check("t6_oe_driven", 32'(sda_oe), 32'd1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("t6_oe_released", 32'(sda_oe), 32'd0);
    check("t6_busy_cleared", 32'(busy), 32'd0);
    reset = 1'b0;
    scl = 1'b1;
    m_low = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    for (int i = 0; i < 16; i++) peek_chk(4'(i), "t6_peek_zero");

    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
